// File: rtl/slave_port_arbiter.sv
// Purpose: round-robin arbiter sharing one slow slave port among NUM_MASTERS masters.
// Latency: request to m_ack is 2 cycles minimum; back-to-back transactions take 3+ cycles each.
// Backpressure: masters hold m_req until their m_ack pulse. The slave stalls by withholding s_ack,
//   and the watchdog bounds that stall at TIMEOUT_CYCLES.
// Ports:
//   PCLK, PRESET          clock and synchronous active-high reset
//   m_req/m_cmd           per-master request and command (1 = write, 0 = read)
//   m_addr/m_wdata        per-master 32-bit fields, packed 32 bits per master
//   m_ack/m_err           one-cycle completion pulse and its timeout flag
//   m_rdata               per-master read data, held until that master's next read completes
//   s_req/s_cmd/s_addr/s_wdata/s_ack/s_rdata   single slave port
//   grant_id, busy, timeout_cnt                status
module slave_port_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ID_W           = $clog2(NUM_MASTERS)
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NUM_MASTERS-1:0]   m_req,
  input  logic [NUM_MASTERS-1:0]   m_cmd,
  input  logic [NUM_MASTERS*32-1:0] m_addr,
  input  logic [NUM_MASTERS*32-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]   m_ack,
  output logic [NUM_MASTERS-1:0]   m_err,
  output logic [NUM_MASTERS*32-1:0] m_rdata,
  output logic                     s_req,
  output logic                     s_cmd,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic                     s_ack,
  input  logic [31:0]              s_rdata,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic [7:0]               timeout_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] winner;
  logic            any_req;
  logic [15:0]     wdog;
  logic            err;
  logic            expire;

  // The watchdog counts from 0 in the first BUSY cycle, so hitting TIMEOUT_CYCLES-1
  // means BUSY has lasted exactly TIMEOUT_CYCLES cycles.
  assign expire = (wdog == 16'(TIMEOUT_CYCLES - 1));

  // Round-robin search starting just after the last grant, so the previous
  // winner is checked last.
  always_comb begin : rr_pick
    int idx;
    idx     = 0;
    winner  = last_grant;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(last_grant) + k) % NUM_MASTERS;
      if (!any_req && m_req[idx]) begin
        any_req = 1'b1;
        winner  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (s_ack || expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slave request and status are decoded from the state, so a master dropping
  // m_req mid-transaction cannot abort the slave access.
  assign s_req = (state == BUSY);
  assign busy  = (state != IDLE);

  always_comb begin
    m_ack = '0;
    m_err = '0;
    if (state == RESP) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (grant_id == ID_W'(i)) begin
          m_ack[i] = 1'b1;
          m_err[i] = err;
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      last_grant  <= ID_W'(NUM_MASTERS - 1);
      grant_id    <= '0;
      s_cmd       <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      wdog        <= '0;
      err         <= 1'b0;
      timeout_cnt <= '0;
      m_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id   <= winner;
            last_grant <= winner;
            wdog       <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
              if (winner == ID_W'(i)) begin
                s_cmd   <= m_cmd[i];
                s_addr  <= m_addr[i*32 +: 32];
                s_wdata <= m_wdata[i*32 +: 32];
              end
            end
          end
        end
        BUSY: begin
          // Ack takes priority over a watchdog expiry in the same cycle.
          if (s_ack) begin
            err <= 1'b0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
              if (!s_cmd && grant_id == ID_W'(i)) m_rdata[i*32 +: 32] <= s_rdata;
            end
          end else if (expire) begin
            err <= 1'b1;
            for (int i = 0; i < NUM_MASTERS; i++) begin
              if (!s_cmd && grant_id == ID_W'(i)) m_rdata[i*32 +: 32] <= 32'hDEAD_BEEF;
            end
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_port_arbiter.sv
module tb_slave_port_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam int IW = 2;

  logic            PCLK, PRESET;
  logic [N-1:0]    m_req, m_cmd, m_ack, m_err;
  logic [N*32-1:0] m_addr, m_wdata, m_rdata;
  logic            s_req, s_cmd, s_ack, busy;
  logic [31:0]     s_addr, s_wdata, s_rdata;
  logic [IW-1:0]   grant_id;
  logic [7:0]      timeout_cnt;

  logic            cmd_a[N];
  logic [31:0]     addr_a[N];
  logic [31:0]     wdata_a[N];
  logic [31:0]     rd_a[N];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: transaction-level view of the arbiter.
  int          mdl_last;
  logic [31:0] mdl_rdata[N];
  int          mdl_tcnt;

  slave_port_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO), .ID_W(IW)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .grant_id(grant_id), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_cmd[i]             = cmd_a[i];
      m_addr[32*i +: 32]   = addr_a[i];
      m_wdata[32*i +: 32]  = wdata_a[i];
      rd_a[i]              = m_rdata[32*i +: 32];
    end
  end

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic int mdl_pick(input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (mdl_last + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N*32-1:0] mdl_pack();
    logic [N*32-1:0] r;
    for (int i = 0; i < N; i++) r[32*i +: 32] = mdl_rdata[i];
    return r;
  endfunction

  task automatic mdl_reset();
    mdl_last = N - 1;
    mdl_tcnt = 0;
    for (int i = 0; i < N; i++) mdl_rdata[i] = '0;
  endtask

  task automatic set_req(input int i, input logic c, input logic [31:0] a, input logic [31:0] w);
    cmd_a[i]   = c;
    addr_a[i]  = a;
    wdata_a[i] = w;
    m_req[i]   = 1'b1;
  endtask

  task automatic apply_reset();
    PRESET  = 1'b1;
    m_req   = '0;
    s_ack   = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      cmd_a[i] = 1'b0; addr_a[i] = '0; wdata_a[i] = '0;
    end
    tick();
    PRESET = 1'b0;
    mdl_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (m_ack !== 4'b0) $display("FAIL reset m_ack got=%b exp=0", m_ack); else n_pass++;
    n_checks++; if (m_err !== 4'b0) $display("FAIL reset m_err got=%b exp=0", m_err); else n_pass++;
    n_checks++; if (m_rdata !== mdl_pack()) $display("FAIL reset m_rdata got=%h exp=%h", m_rdata, mdl_pack()); else n_pass++;
    n_checks++; if ({s_req, s_cmd} !== 2'b00) $display("FAIL reset s_req/s_cmd got=%b exp=00", {s_req, s_cmd}); else n_pass++;
    n_checks++; if ({s_addr, s_wdata} !== 64'h0) $display("FAIL reset s_addr/s_wdata got=%h exp=0", {s_addr, s_wdata}); else n_pass++;
    n_checks++; if (grant_id !== 2'd0) $display("FAIL reset grant_id got=%0d exp=0", grant_id); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (timeout_cnt !== 8'd0) $display("FAIL reset timeout_cnt got=%0d exp=0", timeout_cnt); else n_pass++;
  endtask

  task automatic test_single_read();
    int exp;
    set_req(0, 1'b0, 32'h0000_0010, 32'h0);
    exp = mdl_pick(m_req);
    mdl_last = exp;
    tick();
    n_checks++; if ({grant_id, s_cmd, s_addr} !== {IW'(exp), 1'b0, 32'h10})
      $display("FAIL single_read grant got=%0d/%b/%h exp=%0d/0/00000010", grant_id, s_cmd, s_addr, exp); else n_pass++;
    for (int c = 1; c <= 3; c++) begin
      n_checks++; if (s_req !== 1'b1 || m_ack !== 4'b0)
        $display("FAIL single_read busy cycle %0d s_req=%b m_ack=%b exp 1/0000", c, s_req, m_ack); else n_pass++;
      if (c == 3) begin s_ack = 1'b1; s_rdata = 32'h1234_5678; end
      if (c < 3) tick();
    end
    tick();
    s_ack = 1'b0;
    mdl_rdata[0] = 32'h1234_5678;
    n_checks++; if (m_ack !== 4'b0001) $display("FAIL single_read m_ack got=%b exp=0001", m_ack); else n_pass++;
    n_checks++; if (m_err !== 4'b0000) $display("FAIL single_read m_err got=%b exp=0000", m_err); else n_pass++;
    n_checks++; if (rd_a[0] !== mdl_rdata[0]) $display("FAIL single_read rdata got=%h exp=%h", rd_a[0], mdl_rdata[0]); else n_pass++;
    m_req = '0;
    tick();
    n_checks++; if ({busy, m_ack} !== 5'b0) $display("FAIL single_read idle busy/m_ack got=%b exp=0", {busy, m_ack}); else n_pass++;
  endtask

  task automatic test_round_robin();
    int acks[N];
    int exp;
    logic [31:0] rdv;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      acks[i] = 0;
      set_req(i, 1'b0, $urandom, 32'h0);
    end
    for (int g = 0; g < 5; g++) begin
      exp = mdl_pick(m_req);
      mdl_last = exp;
      tick();
      n_checks++; if (grant_id !== IW'(exp)) $display("FAIL round_robin grant %0d got=%0d exp=%0d", g, grant_id, exp); else n_pass++;
      tick();
      rdv = $urandom; s_ack = 1'b1; s_rdata = rdv;
      tick();
      s_ack = 1'b0;
      mdl_rdata[exp] = rdv;
      n_checks++; if (m_ack !== 4'(1 << exp)) $display("FAIL round_robin m_ack got=%b exp=%b", m_ack, 4'(1 << exp)); else n_pass++;
      n_checks++; if (rd_a[exp] !== rdv) $display("FAIL round_robin rdata got=%h exp=%h", rd_a[exp], rdv); else n_pass++;
      for (int i = 0; i < N; i++) acks[i] += int'((m_ack >> i) & 4'b1);
      if (g == 4) m_req = '0;
      tick();
      if (g == 3) begin
        for (int i = 0; i < N; i++) begin
          n_checks++; if (acks[i] != 1) $display("FAIL round_robin ack count master %0d got=%0d exp=1", i, acks[i]); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_write_latching();
    int exp;
    set_req(2, 1'b1, 32'h8000_0004, 32'hCAFE_0001);
    exp = mdl_pick(m_req);
    mdl_last = exp;
    tick();
    n_checks++; if ({grant_id, s_cmd} !== {IW'(exp), 1'b1}) $display("FAIL write_latch grant got=%0d/%b exp=%0d/1", grant_id, s_cmd, exp); else n_pass++;
    m_req[2] = 1'b0; addr_a[2] = $urandom; wdata_a[2] = $urandom; cmd_a[2] = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      n_checks++; if ({s_req, s_addr, s_wdata} !== {1'b1, 32'h8000_0004, 32'hCAFE_0001})
        $display("FAIL write_latch hold cycle %0d got=%b/%h/%h exp=1/80000004/cafe0001", c, s_req, s_addr, s_wdata); else n_pass++;
      if (c == 4) begin s_ack = 1'b1; s_rdata = $urandom; end
    end
    tick();
    s_ack = 1'b0;
    n_checks++; if ({m_ack, m_err} !== 8'b0100_0000) $display("FAIL write_latch ack/err got=%b/%b exp=0100/0000", m_ack, m_err); else n_pass++;
    n_checks++; if (m_rdata !== mdl_pack()) $display("FAIL write_latch m_rdata got=%h exp=%h", m_rdata, mdl_pack()); else n_pass++;
    tick();
  endtask

  task automatic test_read_timeout();
    int exp;
    apply_reset();
    set_req(1, 1'b0, $urandom, 32'h0);
    exp = mdl_pick(m_req);
    mdl_last = exp;
    tick();
    for (int c = 1; c <= TO; c++) begin
      n_checks++; if ({busy, s_req, m_ack} !== 6'b11_0000)
        $display("FAIL read_timeout busy cycle %0d busy/s_req/m_ack got=%b exp=110000", c, {busy, s_req, m_ack}); else n_pass++;
      tick();
    end
    mdl_rdata[exp] = 32'hDEAD_BEEF;
    mdl_tcnt++;
    n_checks++; if (m_ack !== 4'b0010) $display("FAIL read_timeout m_ack got=%b exp=0010", m_ack); else n_pass++;
    n_checks++; if (m_err !== 4'b0010) $display("FAIL read_timeout m_err got=%b exp=0010", m_err); else n_pass++;
    n_checks++; if (rd_a[1] !== mdl_rdata[1]) $display("FAIL read_timeout rdata got=%h exp=%h", rd_a[1], mdl_rdata[1]); else n_pass++;
    n_checks++; if (timeout_cnt !== 8'(mdl_tcnt)) $display("FAIL read_timeout timeout_cnt got=%0d exp=%0d", timeout_cnt, mdl_tcnt); else n_pass++;
    m_req = '0;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL read_timeout idle busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_coincident();
    int exp;
    logic [31:0] rdv;
    rdv = $urandom;
    set_req(3, 1'b0, $urandom, 32'h0);
    exp = mdl_pick(m_req);
    mdl_last = exp;
    tick();
    for (int c = 1; c <= TO; c++) begin
      if (c == TO) begin s_ack = 1'b1; s_rdata = rdv; end
      tick();
    end
    s_ack = 1'b0;
    mdl_rdata[exp] = rdv;
    n_checks++; if (m_ack !== 4'(1 << exp)) $display("FAIL coincident m_ack got=%b exp=%b", m_ack, 4'(1 << exp)); else n_pass++;
    n_checks++; if (m_err !== 4'b0) $display("FAIL coincident m_err got=%b exp=0000", m_err); else n_pass++;
    n_checks++; if (rd_a[3] !== rdv) $display("FAIL coincident rdata got=%h exp=%h", rd_a[3], rdv); else n_pass++;
    n_checks++; if (timeout_cnt !== 8'(mdl_tcnt)) $display("FAIL coincident timeout_cnt got=%0d exp=%0d", timeout_cnt, mdl_tcnt); else n_pass++;
    m_req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    int exp;
    logic [N-1:0] saw;
    logic [31:0] rdv;
    set_req(0, 1'b0, $urandom, 32'h0);
    tick();
    tick();
    PRESET = 1'b1;
    m_req  = '0;
    tick();
    PRESET = 1'b0;
    mdl_reset();
    n_checks++; if ({s_req, busy, m_ack} !== 6'b0) $display("FAIL reset_mid s_req/busy/m_ack got=%b exp=0", {s_req, busy, m_ack}); else n_pass++;
    n_checks++; if (m_rdata !== mdl_pack()) $display("FAIL reset_mid m_rdata got=%h exp=%h", m_rdata, mdl_pack()); else n_pass++;
    saw = '0;
    repeat (3) begin
      tick();
      saw |= m_ack;
    end
    n_checks++; if (saw !== 4'b0) $display("FAIL reset_mid stray m_ack got=%b exp=0000", saw); else n_pass++;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, $urandom, 32'h0);
    exp = mdl_pick(m_req);
    mdl_last = exp;
    tick();
    n_checks++; if (grant_id !== IW'(exp)) $display("FAIL reset_mid first grant got=%0d exp=%0d", grant_id, exp); else n_pass++;
    rdv = $urandom; s_ack = 1'b1; s_rdata = rdv;
    tick();
    s_ack = 1'b0;
    mdl_rdata[exp] = rdv;
    n_checks++; if (m_ack !== 4'(1 << exp)) $display("FAIL reset_mid m_ack got=%b exp=%b", m_ack, 4'(1 << exp)); else n_pass++;
    m_req = '0;
    tick();
  endtask

  task automatic new_req(input int i);
    cmd_a[i]   = 1'($urandom_range(0, 1));
    addr_a[i]  = $urandom;
    wdata_a[i] = $urandom;
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    int exp, d, nb;
    logic e_cmd, e_err, bad;
    logic [31:0] e_addr, e_wdata, rdv;
    apply_reset();
    pend = '0;
    repeat (40) begin
      n_checks++; if ({busy, m_ack} !== 5'b0) $display("FAIL random idle busy/m_ack got=%b exp=0", {busy, m_ack}); else n_pass++;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin pend[i] = 1'b1; new_req(i); end
      end
      if (pend == '0) begin
        d = $urandom_range(0, N - 1);
        pend[d] = 1'b1;
        new_req(d);
      end
      m_req = pend;
      exp = mdl_pick(pend);
      mdl_last = exp;
      e_cmd = cmd_a[exp]; e_addr = addr_a[exp]; e_wdata = wdata_a[exp];
      tick();
      n_checks++; if ({grant_id, s_cmd, s_addr, s_wdata} !== {IW'(exp), e_cmd, e_addr, e_wdata})
        $display("FAIL random grant got=%0d/%b/%h/%h exp=%0d/%b/%h/%h", grant_id, s_cmd, s_addr, s_wdata, exp, e_cmd, e_addr, e_wdata); else n_pass++;
      d = $urandom_range(1, TO + 3);
      nb = (d < TO) ? d : TO;
      bad = 1'b0;
      rdv = '0;
      for (int c = 1; c <= nb; c++) begin
        if (s_req !== 1'b1) bad = 1'b1;
        if (c == d) begin rdv = $urandom; s_ack = 1'b1; s_rdata = rdv; end
        tick();
      end
      s_ack = 1'b0;
      n_checks++; if (bad !== 1'b0) $display("FAIL random s_req dropped during busy got=0 exp=1"); else n_pass++;
      if (d <= TO) begin
        e_err = 1'b0;
        if (!e_cmd) mdl_rdata[exp] = rdv;
      end else begin
        e_err = 1'b1;
        if (!e_cmd) mdl_rdata[exp] = 32'hDEAD_BEEF;
        if (mdl_tcnt < 255) mdl_tcnt++;
      end
      n_checks++; if ({m_ack, m_err} !== {4'(1 << exp), e_err ? 4'(1 << exp) : 4'b0})
        $display("FAIL random ack/err got=%b/%b exp master %0d err %b", m_ack, m_err, exp, e_err); else n_pass++;
      n_checks++; if (m_rdata !== mdl_pack()) $display("FAIL random m_rdata got=%h exp=%h", m_rdata, mdl_pack()); else n_pass++;
      n_checks++; if (timeout_cnt !== 8'(mdl_tcnt)) $display("FAIL random timeout_cnt got=%0d exp=%0d", timeout_cnt, mdl_tcnt); else n_pass++;
      pend[exp] = 1'b0;
      m_req = pend;
      tick();
    end
    m_req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_latching();
    test_read_timeout();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/slave_port_arbiter.md
# slave_port_arbiter

Round-robin arbiter that shares one slave port among `NUM_MASTERS` masters using the crossbar req/cmd/addr/wdata/ack/rdata handshake. It latches the winning request, drives the slave until the slave acks or a watchdog expires, and returns a one-cycle ack with read data or an error flag to the granted master. It sits between the masters and a single slow peripheral that the crossbar cannot route to independently.

## Interface
Parameters:
- `NUM_MASTERS`, default 4, number of requesters, range 2..8.
- `TIMEOUT_CYCLES`, default 255, maximum number of BUSY cycles before an error completion, range 2..65535.
- `ID_W`, default `$clog2(NUM_MASTERS)`, width of `grant_id`.

Ports:
- **Clock and reset:** one clock; reset is synchronous and active-high.
  - `PCLK` in 1: clock. All logic is on the rising edge.
  - `PRESET` in 1: synchronous, active-high reset.
- **Master side:**
  - `m_req` in N: request, one bit per master, held until that master's ack.
  - `m_cmd` in N: command per master, 1 = write, 0 = read.
  - `m_addr` in N*32: master i uses bits [32i+31:32i].
  - `m_wdata` in N*32: write data, same packing as `m_addr`.
  - `m_ack` out N: one-cycle completion pulse per master.
  - `m_err` out N: asserted together with `m_ack` on a timeout completion.
  - `m_rdata` out N*32: per-master read data register. It holds its value until that master's next read completes.
- **Slave side:**
  - `s_req` out 1: request to the slave.
  - `s_cmd` out 1, `s_addr` out 32, `s_wdata` out 32: latched copy of the granted request.
  - `s_ack` in 1: slave completion. Sampled only in BUSY. `s_rdata` is valid in the same cycle.
  - `s_rdata` in 32: slave read data.
- **Status:**
  - `grant_id` out ID_W: index of the current or last granted master.
  - `busy` out 1: high whenever the block is not in IDLE.
  - `timeout_cnt` out 8: saturating count of timeout completions.

## Operation
**States.** The FSM has three states: IDLE, BUSY and RESP.

**IDLE**
- If any `m_req` bit is set, pick a winner round-robin. The search starts at `last_grant+1` and wraps modulo N.
- On the clock edge:
  - `grant_id` and `last_grant` take the winner.
  - `s_cmd`, `s_addr` and `s_wdata` load the winner's fields.
  - The watchdog counter clears.
  - The state moves to BUSY.
- `s_ack` is ignored in IDLE.

**BUSY**
- `s_req` = 1. It is decoded from the state, not from `m_req`.
- The latched `s_*` fields hold. A master dropping `m_req` mid-transaction does not abort it.
- If `s_ack` = 1:
  - if `s_cmd` = 0, capture `s_rdata` into the granted master's `m_rdata` slice;
  - go to RESP with error = 0.
- Otherwise, if the counter equals `TIMEOUT_CYCLES`-1:
  - go to RESP with error = 1;
  - if the command was a read, load 32'hDEAD_BEEF into the granted `m_rdata` slice;
  - increment `timeout_cnt`, saturating at 255.
- Otherwise the counter increments.
- If `s_ack` and the watchdog expiry coincide, the ack wins.

**RESP**
- `m_ack[grant_id]` = 1 for exactly this cycle. `m_err[grant_id]` equals the stored error flag.
- `s_req` = 0.
- The state moves to IDLE unconditionally.

**Fairness**
- After a grant to master k, master k has the lowest priority.
- A master holding `m_req` continuously is re-granted only if no other master requests in that IDLE cycle.

**Reset**
- After reset, `last_grant` = N-1, so master 0 wins the first contention.
- A reset asserted mid-transaction returns the block to IDLE on that edge.
  - `s_req` drops in the next cycle.
  - No `m_ack` is generated for the aborted transaction.

## Timing
**Reset values.**
- `m_ack` = 0, `m_err` = 0, `m_rdata` = 0.
- `s_req` = 0, `s_cmd` = 0, `s_addr` = 0, `s_wdata` = 0.
- `grant_id` = 0, `busy` = 0, `timeout_cnt` = 0.
- State = IDLE, watchdog counter = 0.

**Outputs.** All outputs are registered or decoded from the state.
- `m_ack`, `m_err` and `m_rdata` are valid together in the RESP cycle.
- `m_rdata` then holds.

**Latency.**
- Request seen in IDLE at cycle 0:
  - `s_req` is high in cycle 1;
  - if `s_ack` arrives in cycle j ≥ 1, `m_ack` pulses in cycle j+1;
  - the block is back in IDLE in cycle j+2.
- Minimum request-to-ack latency is 2 cycles. Back-to-back transactions take at least 3 cycles each.
- A timeout gives BUSY = `TIMEOUT_CYCLES` cycles exactly, so `m_ack`/`m_err` arrive at cycle `TIMEOUT_CYCLES`+1.

**Master rule.** A master samples `m_ack` at the end of RESP and must drop `m_req` or present its next request starting the following cycle.

## Test plan
1. **Single read.** Reset; master 0 reads address 0x0000_0010; slave acks in cycle 3 with `s_rdata` 0x1234_5678.
   - `s_req` is high in cycles 1–3.
   - `m_ack[0]` pulses in cycle 4 and `m_rdata[31:0]` = 0x1234_5678.
   - `m_err` = 0 and `busy` returns to 0 in cycle 5.
2. **Round-robin.** All 4 masters hold `m_req`; the slave acks 1 cycle after each `s_req`.
   - Grant order is 0, 1, 2, 3, 0.
   - Each master gets exactly one `m_ack` per 4 grants.
3. **Write latching.** Master 2 writes 0xCAFE_0001 to 0x8000_0004, then drops `m_req` one cycle after the grant.
   - `s_req`, `s_addr` and `s_wdata` hold until `s_ack`.
   - `m_ack[2]` still pulses.
   - `m_rdata` is unchanged.
4. **Read timeout.** `TIMEOUT_CYCLES`=8; master 1 reads and the slave never acks.
   - BUSY lasts 8 cycles.
   - In cycle 9: `m_ack[1]` = `m_err[1]` = 1, `m_rdata[63:32]` = 0xDEAD_BEEF, `timeout_cnt` = 1.
5. **Coincident ack and expiry.** `s_ack` arrives in the 8th BUSY cycle with `TIMEOUT_CYCLES`=8.
   - Normal completion: `m_err` = 0, the `s_rdata` value is returned, `timeout_cnt` is unchanged.
6. **Reset mid-transaction.** `PRESET` is pulsed during BUSY.
   - State returns to IDLE and `s_req` = 0 on the next cycle.
   - No `m_ack` is generated.
   - The next contention is won by master 0.
